// File: rtl/absorb_load_stage.sv
// rtl/absorb_load_stage.sv - packs message words into SHAKE rate blocks with padding
// Emits one padded block at a time to the permute stage over a valid/ready handshake.
module absorb_load_stage #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [31:0]         cmd_input_size,
  input  logic [31:0]         cmd_output_size,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [W-1:0]        din,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [RATE_MAX-1:0] rate_out,
  output logic [1:0]          operation_mode_out,
  output logic [31:0]         output_size_out,
  output logic                first_block,
  output logic                last_block,
  output logic                busy
);

  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;
  localparam int         RATE_256          = 1088;
  localparam int         WPB_128           = RATE_MAX / W;
  localparam int         WPB_256           = RATE_256 / W;
  localparam int         LANES             = W / 8;
  localparam logic [4:0] LAST_IDX_128      = 5'(WPB_128 - 1);
  localparam logic [4:0] LAST_IDX_256      = 5'(WPB_256 - 1);
  localparam logic [W-1:0] DOMAIN_WORD     = {8'h1F, {(W-8){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, PAD, PRESENT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [31:0]   out_size_q, out_size_d;
  logic [31:0]   bytes_left_q, bytes_left_d;
  logic [4:0]    word_idx_q, word_idx_d;
  logic          pad_done_q, pad_done_d;
  logic          first_q, first_d;
  logic [W-1:0]  blk_q [WPB_128];

  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          clr_blk;
  logic [4:0]    last_idx;
  logic [2:0]    tail_bytes;
  logic [W-1:0]  tail_word;

  assign last_idx   = (mode_q == SHAKE128_MODE_VEC) ? LAST_IDX_128 : LAST_IDX_256;
  assign tail_bytes = bytes_left_q[2:0];

  // Final partial word: keep the message lanes, drop stale lanes, insert the domain byte.
  always_comb begin
    tail_word = '0;
    for (int j = 0; j < LANES; j++) begin
      if (j < int'(tail_bytes)) begin
        tail_word[W-1-8*j -: 8] = din[W-1-8*j -: 8];
      end else if (j == int'(tail_bytes)) begin
        tail_word[W-1-8*j -: 8] = 8'h1F;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    out_size_d   = out_size_q;
    bytes_left_d = bytes_left_q;
    word_idx_d   = word_idx_q;
    pad_done_d   = pad_done_q;
    first_d      = first_q;
    wr_en        = 1'b0;
    wr_data      = '0;
    clr_blk      = 1'b0;
    cmd_ready    = 1'b0;
    din_ready    = 1'b0;
    blk_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_mode == SHAKE128_MODE_VEC || cmd_mode == SHAKE256_MODE_VEC)) begin
          mode_d       = cmd_mode;
          out_size_d   = cmd_output_size;
          bytes_left_d = cmd_input_size;
          word_idx_d   = 5'd0;
          pad_done_d   = 1'b0;
          first_d      = 1'b1;
          state_d      = (cmd_input_size != 32'd0) ? FILL : PAD;
        end
      end

      FILL: begin
        din_ready = 1'b1;
        if (din_valid) begin
          wr_en = 1'b1;
          if (bytes_left_q >= 32'd8) begin
            wr_data      = din;
            bytes_left_d = bytes_left_q - 32'd8;
          end else begin
            wr_data      = tail_word;
            bytes_left_d = 32'd0;
            pad_done_d   = 1'b1;
          end
          if (word_idx_q == last_idx) begin
            state_d = PRESENT;
          end else begin
            word_idx_d = word_idx_q + 5'd1;
            if (bytes_left_d == 32'd0) state_d = PAD;
          end
        end
      end

      PAD: begin
        wr_en      = 1'b1;
        wr_data    = pad_done_q ? '0 : DOMAIN_WORD;
        pad_done_d = 1'b1;
        if (word_idx_q == last_idx) begin
          state_d = PRESENT;
        end else begin
          word_idx_d = word_idx_q + 5'd1;
        end
      end

      PRESENT: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          clr_blk    = 1'b1;
          first_d    = 1'b0;
          word_idx_d = 5'd0;
          if (pad_done_q)                 state_d = IDLE;
          else if (bytes_left_q != 32'd0) state_d = FILL;
          else                            state_d = PAD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mode_q       <= 2'b00;
      out_size_q   <= 32'd0;
      bytes_left_q <= 32'd0;
      word_idx_q   <= 5'd0;
      pad_done_q   <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      out_size_q   <= out_size_d;
      bytes_left_q <= bytes_left_d;
      word_idx_q   <= word_idx_d;
      pad_done_q   <= pad_done_d;
      first_q      <= first_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WPB_128; k++) blk_q[k] <= '0;
    end else if (clr_blk) begin
      for (int k = 0; k < WPB_128; k++) blk_q[k] <= '0;
    end else if (wr_en) begin
      blk_q[word_idx_q] <= wr_data;
    end
  end

  // The closing 0x80 always lands in the lowest byte of rate_out, whichever rate is active.
  always_comb begin
    rate_out = '0;
    if (mode_q == SHAKE128_MODE_VEC) begin
      for (int k = 0; k < WPB_128; k++) rate_out[RATE_MAX-1-W*k -: W] = blk_q[k];
    end else begin
      for (int k = 0; k < WPB_256; k++) rate_out[RATE_256-1-W*k -: W] = blk_q[k];
    end
    if (state_q == PRESENT && pad_done_q) rate_out[7:0] = rate_out[7:0] | 8'h80;
  end

  assign operation_mode_out = mode_q;
  assign output_size_out    = out_size_q;
  assign first_block        = (state_q == PRESENT) && first_q;
  assign last_block         = (state_q == PRESENT) && pad_done_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: doc/absorb_load_stage.md
Name: absorb_load_stage

Overview:
- Front-end stage directly upstream of the permute/dump datapath.
- Accepts a command carrying mode, message length and requested output size, then a stream of 64-bit message words.
- Packs the words into rate-sized blocks and applies SHAKE padding (0x1F domain byte, 0x80 final byte).
- Hands each block, with its mode, output size and first/last flags, to the permute stage over a valid/ready handshake.

Parameters:
- W, 64: message word width in bits; equals w from keccak_pkg.
- RATE_MAX, 1344: width of rate_out; equals RATE_SHAKE128.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_mode  in  2  SHAKE128_MODE_VEC or SHAKE256_MODE_VEC.
- cmd_input_size  in  32  message length in bytes.
- cmd_output_size  in  32  requested output length in bits; passed through unchanged.
- din_valid  in  1  message word valid.
- din_ready  out  1  message word accepted when din_valid && din_ready.
- din  in  W  message word; message byte j of the word sits in din[63-8j -: 8].
- blk_valid  out  1  padded block available.
- blk_ready  in  1  downstream consumes the block.
- rate_out  out  RATE_MAX  block; word k at rate_out[R-1-64k -: 64], where R = 1344 (SHAKE128) or 1088 (SHAKE256); bits above R are zero.
- operation_mode_out  out  2  registered cmd_mode.
- output_size_out  out  32  registered cmd_output_size.
- first_block  out  1  this is the first block of the command.
- last_block  out  1  this block contains the padding.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, except cmd_ready, which is 1.
  - Block register, counters and flags clear. Applies the same way mid-operation; a partial block is discarded.
- Words per block (WPB): 21 for SHAKE128, 17 for SHAKE256.
- Unsupported cmd_mode: command is accepted and dropped; state stays IDLE and no block is produced.
- Internal counters:
  - bytes_left, 32 bits, loaded from cmd_input_size.
  - word_idx, 5 bits, range 0..WPB-1.
  - pad_done flag.
- States:
  - IDLE:
    - cmd_ready=1.
    - On accept: latch mode and output size; load bytes_left; word_idx=0; pad_done=0; first=1.
    - Next state: FILL if bytes_left>0, else PAD.
  - FILL:
    - din_ready=1; each accepted word is written at word_idx.
    - bytes_left>=8: word stored as-is; bytes_left-=8.
    - bytes_left=r<8: lanes 0..r-1 kept, lane r=0x1F, lanes r+1..7=0; bytes_left=0; pad_done=1. Stale bytes in din are discarded.
    - Word written at word_idx=WPB-1 → PRESENT.
    - bytes_left reaches 0 mid-block → PAD.
    - Words beyond ceil(size/8) are never accepted.
  - PAD:
    - din_ready=0; one word written per cycle.
    - First word written is 0x1F in lane 0 if pad_done=0 (then pad_done=1); later words are 0.
    - After the word at WPB-1 → PRESENT.
  - PRESENT:
    - blk_valid=1.
    - rate_out, flags, mode and size are held stable until blk_ready.
    - If pad_done, byte R/8-1 (word WPB-1, lane 7) is ORed with 0x80. When 0x1F lands there, that byte is 0x9F.
    - last_block = pad_done.
    - On handshake, next state:
      - IDLE if pad_done;
      - else FILL if bytes_left>0;
      - else PAD. This is the case where the message ended exactly on a block boundary, giving an extra pad-only block.
    - first clears; word_idx=0; block register cleared to 0.
- Latency:
  - blk_valid rises the cycle after the final word write.
  - Pad-only block: 1 cycle to leave PRESENT, then WPB cycles of PAD, then blk_valid.
  - cmd_ready returns 1 the cycle after the final handshake.
- Unused upper bits of rate_out are 0 in SHAKE256 mode.
- din_valid while not in FILL: ignored; din_ready stays 0.
- cmd_valid while busy: not accepted.

Test Plan:
- SHAKE128, size 0 → one block:
  - word0=64'h1F00_0000_0000_0000; word20=64'h0000_0000_0000_0080; others 0.
  - first_block=last_block=1; 0 din handshakes.
- SHAKE256, size 135, 17 words → byte 134 is last message byte; byte 135 = 0x9F; last_block=1; rate_out[1343:1088]=0.
- SHAKE128, size 168 (21 words) → two blocks:
  - block 1: message only, first=1, last=0.
  - block 2: byte0=0x1F, byte167=0x80, first=0, last=1.
- SHAKE256, size 20, third din word = 64'hAAAA_AAAA_FFFF_FFFF:
  - word2 = 64'hAAAA_AAAA_1F00_0000; words 3..15=0; word16=0x80.
  - Exactly 3 din handshakes.
- Backpressure: blk_ready held low for 10 cycles in PRESENT → rate_out and flags stable, din_ready=0, cmd_ready=0; on release, next block fills correctly.
- rst pulsed low mid-FILL (word_idx=7) → outputs 0 immediately, cmd_ready=1 after release; a new SHAKE128 size-0 command then produces the block from scenario 1.
